data_ram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data RAM between the CPU load/store port (master 0) and a secondary requester such as a DMA or debug port (master 1).
- Sits between the processor core's RAM interface and the data RAM.
- Registers one accepted command per cycle into a RAM access stage.
- Returns read data one cycle after the access.
- Uses fixed priority to master 0, with a starvation guard for master 1.

---
 rtl/data_ram_arbiter.sv | 133 +++++++++++++
 tb/tb_data_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter sharing a single-port data RAM between the CPU port (m0) and a secondary requester (m1).
// m0 has fixed priority; m1 is forced through after MAX_WAIT consecutive refusals.
module data_ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_gnt_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_rvalid_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_gnt_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_rvalid_o,

  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACC_M0 = 2'd1;
  localparam logic [1:0] ACC_M1 = 2'd2;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [3:0] wait_cnt;
  logic       force_m1;
  logic       cmd_we;
  logic       read_m0;
  logic       read_m1;

  // m1 overrides m0 only once it has been refused MAX_WAIT cycles in a row
  always_comb begin
    force_m1 = m1_req_i && (wait_cnt == WAIT_LIMIT);
    m0_gnt_o = rst && m0_req_i && !force_m1;
    m1_gnt_o = rst && m1_req_i && (!m0_req_i || force_m1);
  end

  always_comb begin
    next_state = IDLE;
    if (m0_gnt_o) begin
      next_state = ACC_M0;
    end else if (m1_gnt_o) begin
      next_state = ACC_M1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (m1_req_i && !m1_gnt_o) begin
      if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // The captured command feeds the RAM directly and holds while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we     <= 1'b0;
      ram_addr_o <= '0;
      ram_sel_o  <= '0;
      ram_data_o <= '0;
    end else if (m0_gnt_o) begin
      cmd_we     <= m0_we_i;
      ram_addr_o <= m0_addr_i;
      ram_sel_o  <= m0_sel_i;
      ram_data_o <= m0_data_i;
    end else if (m1_gnt_o) begin
      cmd_we     <= m1_we_i;
      ram_addr_o <= m1_addr_i;
      ram_sel_o  <= m1_sel_i;
      ram_data_o <= m1_data_i;
    end
  end

  always_comb begin
    ram_ce_o = (state != IDLE);
    ram_we_o = (state != IDLE) && cmd_we;
    read_m0  = (state == ACC_M0) && !cmd_we;
    read_m1  = (state == ACC_M1) && !cmd_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_data_o   <= '0;
      m1_data_o   <= '0;
    end else begin
      m0_rvalid_o <= read_m0;
      m1_rvalid_o <= read_m1;
      if (read_m0) begin
        m0_data_o <= ram_data_i;
      end
      if (read_m1) begin
        m1_data_o <= ram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grants, RAM accesses and read returns.
module tb_data_ram_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = 4;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              rst;
  logic              m0_req_i, m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_data_i;
  logic              m0_gnt_o, m0_rvalid_o;
  logic [DATA_W-1:0] m0_data_o;
  logic              m1_req_i, m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_gnt_o, m1_rvalid_o;
  logic [DATA_W-1:0] m1_data_o;
  logic              ram_ce_o, ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [SEL_W-1:0]  ram_sel_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [DATA_W-1:0] ram_data_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] bench_mem [0:63];

  typedef struct packed {
    logic        v;
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  data_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
    .m0_data_i(m0_data_i), .m0_gnt_o(m0_gnt_o), .m0_data_o(m0_data_o), .m0_rvalid_o(m0_rvalid_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
    .m1_data_i(m1_data_i), .m1_gnt_o(m1_gnt_o), .m1_data_o(m1_data_o), .m1_rvalid_o(m1_rvalid_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: combinational read, byte-masked write at the clock edge
  assign ram_data_i = bench_mem[ram_addr_o[7:2]];
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel_o[b]) bench_mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
      end
    end
  end

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data);
    m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_sel_i = sel; m0_data_i = data;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data);
    m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_sel_i = sel; m1_data_i = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_m0(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    drive_m1(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m0_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_gnt: got %b want 0", m0_gnt_o); end
    checks++; if (m1_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_gnt: got %b want 0", m1_gnt_o); end
    checks++; if (ram_ce_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_ce: got %b want 0", ram_ce_o); end
    checks++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b%b want 00", m0_rvalid_o, m1_rvalid_o); end
    drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_m0_gnt: got %b want 1", m0_gnt_o); end
    next_cycle();
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_write_ce_we: got %b%b want 11", ram_ce_o, ram_we_o); end
    checks++; if (ram_addr_o !== 32'h10 || ram_data_o !== 32'hDEADBEEF || ram_sel_o !== 4'hF) begin errors++; $display("[TB] FAIL post_reset_write_cmd: got %h/%h/%h want 10/deadbeef/f", ram_addr_o, ram_data_o, ram_sel_o); end
    next_cycle();
  endtask

  task automatic test_single_read();
    drive_m1(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL read_gnt: got m0=%b m1=%b want m0=0 m1=1", m0_gnt_o, m1_gnt_o); end
    next_cycle();
    drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b0 || ram_addr_o !== 32'h10) begin errors++; $display("[TB] FAIL read_access: got ce=%b we=%b addr=%h want 1/0/10", ram_ce_o, ram_we_o, ram_addr_o); end
    checks++; if (m1_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL read_early_rvalid: got %b want 0", m1_rvalid_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (m1_rvalid_o !== 1'b1 || m1_data_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_return: got v=%b d=%h want 1/deadbeef", m1_rvalid_o, m1_data_o); end
    checks++; if (m0_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL read_m0_rvalid: got %b want 0", m0_rvalid_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (m1_rvalid_o !== 1'b0 || m1_data_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_pulse_hold: got v=%b d=%h want 0/deadbeef", m1_rvalid_o, m1_data_o); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp1;
    drive_m0(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      exp1 = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
      @(negedge clk);
      checks++; if (m0_gnt_o !== !exp1 || m1_gnt_o !== exp1) begin errors++; $display("[TB] FAIL starve_cycle%0d: got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt_o, m1_gnt_o, !exp1, exp1); end
      next_cycle();
    end
    m1_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL m0_only_cycle%0d: got m0=%b m1=%b want 1/0", i, m0_gnt_o, m1_gnt_o); end
      next_cycle();
    end
    m0_req_i = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_switch();
    drive_m0(1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
    @(negedge clk);
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL switch_m0_gnt: got %b want 1", m0_gnt_o); end
    next_cycle();
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (m1_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL switch_m1_gnt: got %b want 1", m1_gnt_o); end
    checks++; if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 32'h20) begin errors++; $display("[TB] FAIL switch_write_access: got ce=%b we=%b addr=%h want 1/1/20", ram_ce_o, ram_we_o, ram_addr_o); end
    next_cycle();
    drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b0) begin errors++; $display("[TB] FAIL switch_read_access: got ce=%b we=%b want 1/0", ram_ce_o, ram_we_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (m1_rvalid_o !== 1'b1 || m1_data_o !== 32'h12345678) begin errors++; $display("[TB] FAIL switch_raw_data: got v=%b d=%h want 1/12345678", m1_rvalid_o, m1_data_o); end
    next_cycle();
  endtask

  task automatic test_byte_select();
    drive_m0(1'b1, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF);
    next_cycle();
    drive_m0(1'b1, 1'b1, 32'h30, 4'b0010, 32'h0000AB00);
    next_cycle();
    drive_m0(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (ram_we_o !== 1'b1 || ram_sel_o !== 4'b0010) begin errors++; $display("[TB] FAIL bytesel_sel: got we=%b sel=%b want 1/0010", ram_we_o, ram_sel_o); end
    next_cycle();
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();
    @(negedge clk);
    checks++; if (m0_rvalid_o !== 1'b1 || m0_data_o !== 32'hFFFFABFF) begin errors++; $display("[TB] FAIL bytesel_data: got v=%b d=%h want 1/ffffabff", m0_rvalid_o, m0_data_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_m0(1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_gnt: got %b want 1", m0_gnt_o); end
    next_cycle();
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    checks++; if (ram_ce_o !== 1'b0 || ram_we_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ce_we: got %b%b want 00", ram_ce_o, ram_we_o); end
    next_cycle();
    checks++; if (bench_mem[16] !== 32'h0) begin errors++; $display("[TB] FAIL midrst_ram_unchanged: got %h want 0", bench_mem[16]); end
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || ram_ce_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet%0d: got rv=%b%b ce=%b want 0", i, m0_rvalid_o, m1_rvalid_o, ram_ce_o); end
      next_cycle();
    end
    drive_m0(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    next_cycle();
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();
    @(negedge clk);
    checks++; if (m0_rvalid_o !== 1'b1 || m0_data_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_readback: got v=%b d=%h want 1/0", m0_rvalid_o, m0_data_o); end
    next_cycle();
  endtask

  task automatic test_random_traffic();
    logic [31:0] mdl_mem [0:63];
    acc_t slot1, slot2, cur;
    int refused;
    logic g0, g1, g0_prev, g1_prev;
    logic have0, have1;
    logic [31:0] last0, last1;
    for (int i = 0; i < 64; i++) mdl_mem[i] = 32'h0;
    slot1 = '0; slot2 = '0; refused = 0;
    g0_prev = 1'b0; g1_prev = 1'b0; have0 = 1'b0; have1 = 1'b0;
    last0 = 32'h0; last1 = 32'h0;
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) next_cycle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      // A master keeps its command until granted
      if (!m0_req_i || g0_prev)
        drive_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 7) * 4),
                 4'($urandom_range(1, 15)), $urandom);
      if (!m1_req_i || g1_prev)
        drive_m1($urandom_range(0, 4) < 3, 1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 7) * 4),
                 4'($urandom_range(1, 15)), $urandom);
      @(negedge clk);
      g0 = m0_req_i && !(m1_req_i && refused >= MAX_WAIT);
      g1 = m1_req_i && !g0;
      checks++; if (m0_gnt_o !== g0 || m1_gnt_o !== g1) begin errors++; $display("[TB] FAIL rand_gnt@%0d: got m0=%b m1=%b want m0=%b m1=%b", cyc, m0_gnt_o, m1_gnt_o, g0, g1); end
      checks++; if (ram_ce_o !== slot1.v) begin errors++; $display("[TB] FAIL rand_ce@%0d: got %b want %b", cyc, ram_ce_o, slot1.v); end
      if (slot1.v) begin
        checks++; if (ram_we_o !== slot1.we || ram_addr_o !== slot1.addr || ram_sel_o !== slot1.sel) begin errors++; $display("[TB] FAIL rand_access@%0d: got we=%b a=%h s=%h want we=%b a=%h s=%h", cyc, ram_we_o, ram_addr_o, ram_sel_o, slot1.we, slot1.addr, slot1.sel); end
        if (slot1.we) begin
          checks++; if (ram_data_o !== slot1.wdata) begin errors++; $display("[TB] FAIL rand_wdata@%0d: got %h want %h", cyc, ram_data_o, slot1.wdata); end
        end
      end else begin
        checks++; if (ram_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle_we@%0d: got %b want 0", cyc, ram_we_o); end
      end
      if (slot2.v && !slot2.we && !slot2.m) begin last0 = slot2.rdata; have0 = 1'b1; end
      if (slot2.v && !slot2.we && slot2.m) begin last1 = slot2.rdata; have1 = 1'b1; end
      checks++; if (m0_rvalid_o !== (slot2.v && !slot2.we && !slot2.m)) begin errors++; $display("[TB] FAIL rand_rvalid0@%0d: got %b", cyc, m0_rvalid_o); end
      checks++; if (m1_rvalid_o !== (slot2.v && !slot2.we && slot2.m)) begin errors++; $display("[TB] FAIL rand_rvalid1@%0d: got %b", cyc, m1_rvalid_o); end
      if (have0) begin
        checks++; if (m0_data_o !== last0) begin errors++; $display("[TB] FAIL rand_data0@%0d: got %h want %h", cyc, m0_data_o, last0); end
      end
      if (have1) begin
        checks++; if (m1_data_o !== last1) begin errors++; $display("[TB] FAIL rand_data1@%0d: got %h want %h", cyc, m1_data_o, last1); end
      end
      // Advance the model: accesses happen in grant order, so reads see all earlier writes
      if (m1_req_i && !g1) refused = (refused < MAX_WAIT) ? refused + 1 : refused;
      else refused = 0;
      cur = '0;
      if (g0) begin
        cur.v = 1'b1; cur.m = 1'b0; cur.we = m0_we_i; cur.addr = m0_addr_i; cur.sel = m0_sel_i; cur.wdata = m0_data_i;
      end else if (g1) begin
        cur.v = 1'b1; cur.m = 1'b1; cur.we = m1_we_i; cur.addr = m1_addr_i; cur.sel = m1_sel_i; cur.wdata = m1_data_i;
      end
      if (cur.v && cur.we) begin
        for (int b = 0; b < 4; b++)
          if (cur.sel[b]) mdl_mem[cur.addr[7:2]][b*8 +: 8] = cur.wdata[b*8 +: 8];
      end else if (cur.v) begin
        cur.rdata = mdl_mem[cur.addr[7:2]];
      end
      slot2 = slot1;
      slot1 = cur;
      g0_prev = g0;
      g1_prev = g1;
      next_cycle();
    end
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bench_mem[i] = 32'h0;
    rst = 1'b0;
    drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    test_reset();
    test_single_read();
    test_starvation();
    test_switch();
    test_byte_select();
    test_reset_mid();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
